// File: rtl/uart_pkg.sv
// Shared UART frame definitions: receiver state encoding and 8N1 frame constants.
// The transmitter imports the same constants so both ends agree on the frame shape.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Shift a new serial bit in at the MSB so the first (LSB) bit ends in bit 0
    function automatic logic [DATA_BITS-1:0] shift_in_lsb_first(
        input logic [DATA_BITS-1:0] shift,
        input logic                 bit_in
    );
        return {bit_in, shift[DATA_BITS-1:1]};
    endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer bundle: received byte plus status strobes.
// master = the receiver driving the bundle, slave = the consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        input data,
        input valid,
        input frame_err,
        input busy
    );

endinterface : uart_rx_if

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VAL sets the flop value under reset (idle level of the source).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Two-stage capture of the asynchronous input to resolve metastability
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is oversampled at CLKS_PER_BIT clocks per bit;
// the start bit is re-checked at mid-bit and every following bit is sampled
// one full bit period later, i.e. also at mid-bit. A good stop bit publishes
// the byte with a one-cycle valid; a low stop bit gives a one-cycle frame_err
// and the receiver then waits for the line to return high (break handling).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     pin,
    uart_rx_if.master rx_o
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int BIT_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 s2_s;

    rx_state_e            state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 ferr_q,    ferr_d;
    logic                 busy_q,    busy_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_pin (
        .clk (clk),
        .rst (rst),
        .d_i (pin),
        .q_o (s2_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and output decode; strobes default low so they last one cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s2_s == START_LEVEL) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // Still low at mid-bit: real start; otherwise a glitch
                    if (s2_s == START_LEVEL) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d   = shift_in_lsb_first(shift_q, s2_s);
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    // Leaving at mid-stop lets a start edge right after the
                    // stop bit be caught with no dead time
                    cnt_d = '0;
                    if (s2_s == STOP_LEVEL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            BREAK: begin
                // Held-low line: report once, then wait for idle level
                cnt_d = '0;
                if (s2_s == STOP_LEVEL) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign rx_o.data      = data_q;
    assign rx_o.valid     = valid_q;
    assign rx_o.frame_err = ferr_q;
    assign rx_o.busy      = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit.
// Frames are driven on the falling clock edge; outputs are sampled on the
// falling edge by a monitor that counts strobes and timestamps valid pulses.
// Valid timing is measured from the clock edge that first sees the pin low:
// two synchronizer edges plus the 153-cycle receive latency gives 155.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pin = 1'b1;

    uart_rx_if rx_bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pin  (pin),
        .rx_o (rx_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (written only by the processes below)
    int         cyc        = 0;
    int         valid_cnt  = 0;
    int         ferr_cnt   = 0;
    int         both_cnt   = 0;
    int         busy_cnt   = 0;
    int         last_vcyc  = 0;
    int         prev_vcyc  = 0;
    logic [7:0] last_vdata = 8'h00;
    logic [7:0] prev_vdata = 8'h00;

    // Free-running edge counter
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled away from the active edge
    always @(negedge clk) begin
        if (rx_bus.valid) begin
            valid_cnt  <= valid_cnt + 1;
            prev_vcyc  <= last_vcyc;
            last_vcyc  <= cyc;
            prev_vdata <= last_vdata;
            last_vdata <= rx_bus.data;
        end
        if (rx_bus.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (rx_bus.valid && rx_bus.frame_err) both_cnt <= both_cnt + 1;
        if (rx_bus.busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit length in clocks: mode 0 exact, 1 = 16.5 avg (+3%), 2 = 15.5 avg (-3%)
    function automatic int bit_len(input int mode, input int idx);
        case (mode)
            0:       return CPB;
            1:       return (idx % 2 == 1) ? CPB + 1 : CPB;
            2:       return (idx % 2 == 1) ? CPB - 1 : CPB;
            default: return CPB;
        endcase
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame from a falling edge; start_cyc is the edge count at the start
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int mode, output int start_cyc);
        logic [9:0] frame;
        frame     = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            pin = frame[i];
            wait_clks(bit_len(mode, i));
        end
    endtask

    initial begin
        int sc, sc2, v0, f0, b0;
        logic [7:0] c3;

        // Reset state
        rst = 1'b0;
        pin = 1'b1;
        wait_clks(4);
        check_eq("rst_data",  {24'h0, rx_bus.data},  32'h00);
        check_eq("rst_valid", {31'h0, rx_bus.valid}, 32'h0);
        check_eq("rst_ferr",  {31'h0, rx_bus.frame_err}, 32'h0);
        check_eq("rst_busy",  {31'h0, rx_bus.busy},  32'h0);
        rst = 1'b1;
        wait_clks(10);

        // Single exact-baud frame, latency check
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 0, sc);
        wait_clks(20);
        check_eq("a5_nvalid",  valid_cnt - v0, 32'd1);
        check_eq("a5_latency", last_vcyc - sc, 32'd155);
        check_eq("a5_data",    {24'h0, rx_bus.data}, 32'hA5);
        check_eq("a5_ferr",    ferr_cnt - f0, 32'd0);
        check_eq("a5_busy_end", {31'h0, rx_bus.busy}, 32'h0);

        // Back-to-back 00 then FF, no idle gap
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, 0, sc);
        send_frame(8'hFF, 1'b1, 0, sc2);
        wait_clks(20);
        check_eq("b2b_nvalid",  valid_cnt - v0, 32'd2);
        check_eq("b2b_data0",   {24'h0, prev_vdata}, 32'h00);
        check_eq("b2b_data1",   {24'h0, last_vdata}, 32'hFF);
        check_eq("b2b_spacing", last_vcyc - prev_vcyc, 32'd160);
        check_eq("b2b_ferr",    ferr_cnt - f0, 32'd0);

        // 5-cycle glitch on idle line
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        pin = 1'b0;
        wait_clks(5);
        pin = 1'b1;
        wait_clks(40);
        check_eq("gl_busy_seen", {31'h0, (busy_cnt - b0) > 0}, 32'h1);
        check_eq("gl_busy_max",  {31'h0, (busy_cnt - b0) <= CPB / 2 + 1}, 32'h1);
        check_eq("gl_nvalid",    valid_cnt - v0, 32'd0);
        check_eq("gl_ferr",      ferr_cnt - f0, 32'd0);
        check_eq("gl_busy_end",  {31'h0, rx_bus.busy}, 32'h0);

        // Bad stop bit followed by a 40-bit break, then a good frame
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 0, sc);
        wait_clks(20 * CPB);
        check_eq("brk_busy_mid", {31'h0, rx_bus.busy}, 32'h1);
        wait_clks(20 * CPB);
        pin = 1'b1;
        wait_clks(3 * CPB);
        check_eq("brk_nferr",  ferr_cnt - f0, 32'd1);
        check_eq("brk_nvalid", valid_cnt - v0, 32'd0);
        check_eq("brk_data",   {24'h0, rx_bus.data}, 32'hFF);
        check_eq("brk_idle",   {31'h0, rx_bus.busy}, 32'h0);
        v0 = valid_cnt;
        send_frame(8'h81, 1'b1, 0, sc);
        wait_clks(20);
        check_eq("brk_nxt_nvalid", valid_cnt - v0, 32'd1);
        check_eq("brk_nxt_data",   {24'h0, rx_bus.data}, 32'h81);
        check_eq("brk_nxt_ferr",   ferr_cnt - f0, 32'd1);

        // Baud drift +3% and -3%
        for (int m = 1; m <= 2; m++) begin
            v0 = valid_cnt; f0 = ferr_cnt;
            send_frame(8'h55, 1'b1, m, sc);
            wait_clks(20);
            check_eq($sformatf("drift%0d_nvalid", m), valid_cnt - v0, 32'd1);
            check_eq($sformatf("drift%0d_data", m),   {24'h0, last_vdata}, 32'h55);
            check_eq($sformatf("drift%0d_ferr", m),   ferr_cnt - f0, 32'd0);
        end

        // Reset asserted in the middle of data bit 4
        c3 = 8'hC3;
        pin = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            pin = c3[i];
            wait_clks(CPB);
        end
        pin = c3[4];
        wait_clks(CPB / 2);
        check_eq("mid_busy_pre", {31'h0, rx_bus.busy}, 32'h1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_data",  {24'h0, rx_bus.data},  32'h00);
        check_eq("mid_rst_busy",  {31'h0, rx_bus.busy},  32'h0);
        check_eq("mid_rst_valid", {31'h0, rx_bus.valid}, 32'h0);
        check_eq("mid_rst_ferr",  {31'h0, rx_bus.frame_err}, 32'h0);
        wait_clks(3);
        pin = 1'b1;
        wait_clks(2);
        v0 = valid_cnt; f0 = ferr_cnt;
        rst = 1'b1;
        wait_clks(2 * CPB);
        check_eq("post_rst_nvalid", valid_cnt - v0, 32'd0);
        check_eq("post_rst_nferr",  ferr_cnt - f0, 32'd0);
        send_frame(8'hC3, 1'b1, 0, sc);
        wait_clks(20);
        check_eq("c3_nvalid", valid_cnt - v0, 32'd1);
        check_eq("c3_data",   {24'h0, rx_bus.data}, 32'hC3);
        check_eq("c3_ferr",   ferr_cnt - f0, 32'd0);

        check_eq("never_both", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_uart_rx
